fifo_sync_any_entry: RTL and testbench

Single-clock FIFO with arbitrary (non-power-of-two) depth, occupancy count, programmable almost-full/almost-empty flags and optional sticky error flags. It is the single-clock, parametrised successor to the team's even-entry FIFO, and it is used wherever both sides share one clock. Storage is a flop array with a show-ahead read port: `dout` presents the head entry whenever `empty` is low.

---
 rtl/fifo_sync_any_entry_pkg.sv | 33 +++
 rtl/fifo_sync_any_entry_wrap_ptr.sv | 24 ++
 rtl/fifo_sync_any_entry.sv | 117 +++++++++++
 tb/tb_fifo_sync_any_entry.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_any_entry_pkg.sv
// Shared helpers for the synchronous any-depth FIFO: width functions and flag state.
// Used by fifo_sync_any_entry and fifo_wrap_ptr.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } fifo_flags_t;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return ($clog2(depth) < 1) ? 1 : $clog2(depth);
  endfunction

  // Flags are derived from an occupancy value, so they can never disagree with count.
  function automatic fifo_flags_t calc_flags(input int unsigned cnt,
                                             input int unsigned depth,
                                             input int unsigned af,
                                             input int unsigned ae);
    fifo_flags_t f;
    f.full         = (cnt == depth);
    f.almost_full  = (cnt >= af);
    f.empty        = (cnt == 0);
    f.almost_empty = (cnt <= ae);
    return f;
  endfunction

endpackage

// File: rtl/fifo_sync_any_entry_wrap_ptr.sv
// Pointer that counts 0..DEPTH-1 and wraps to 0; no power-of-two assumption.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter  int DEPTH = 6,
  localparam int PW    = int'(ptr_w(DEPTH))
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/fifo_sync_any_entry.sv
// Single-clock FIFO of arbitrary depth with show-ahead dout, count and registered flags.
// Define FIFO_SYNC_ANY_ENTRY_ERR_EN to build the sticky overflow/underflow registers.
module fifo_sync_any_entry
  import fifo_pkg::*;
#(
  parameter  int DEPTH     = 6,
  parameter  int DWIDTH    = 8,
  parameter  int AF_THRESH = DEPTH - 1,
  parameter  int AE_THRESH = 1,
  localparam int CNT_W     = int'(cnt_w(DEPTH))
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] din,
  input  logic              wen,
  output logic              full,
  output logic              almost_full,
  output logic [DWIDTH-1:0] dout,
  input  logic              ren,
  output logic              empty,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PW = int'(ptr_w(DEPTH));
  localparam fifo_flags_t RST_FLAGS = calc_flags(0, DEPTH, AF_THRESH, AE_THRESH);

  if ((DEPTH < 2) || (DWIDTH < 1) || (AF_THRESH < 1) || (AF_THRESH > DEPTH) ||
      (AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_param_err
    $error("fifo_sync_any_entry: illegal DEPTH/DWIDTH/AF_THRESH/AE_THRESH");
  end

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  fifo_flags_t       flags_q;
  fifo_flags_t       flags_nxt;
  logic              wr_fire;
  logic              rd_fire;

  assign wr_fire = wen & ~flags_q.full;
  assign rd_fire = ren & ~flags_q.empty;

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_fire),
    .ptr   (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_fire),
    .ptr   (rd_ptr)
  );

  always_comb begin
    count_nxt = count_q;
    case ({wr_fire, rd_fire})
      2'b10:   count_nxt = count_q + CNT_W'(1);
      2'b01:   count_nxt = count_q - CNT_W'(1);
      default: count_nxt = count_q;
    endcase
    flags_nxt = calc_flags(32'(count_nxt), DEPTH, AF_THRESH, AE_THRESH);
  end

  // Flags are registered from the next count so they land on the same edge as count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      flags_q <= RST_FLAGS;
    end else begin
      count_q <= count_nxt;
      flags_q <= flags_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= din;
    end
  end

  assign dout         = mem[rd_ptr];
  assign count        = count_q;
  assign full         = flags_q.full;
  assign almost_full  = flags_q.almost_full;
  assign empty        = flags_q.empty;
  assign almost_empty = flags_q.almost_empty;

`ifdef FIFO_SYNC_ANY_ENTRY_ERR_EN
  logic ovf_q;
  logic unf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wen & flags_q.full)  ovf_q <= 1'b1;
      if (ren & flags_q.empty) unf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_any_entry.sv
// Directed, table-driven bench for fifo_sync_any_entry (DEPTH=6, AF_THRESH=4, AE_THRESH=2).
module tb_fifo_sync_any_entry;

  localparam int DEPTH  = 6;
  localparam int DWIDTH = 8;
  localparam int CW     = 3;
`ifdef FIFO_SYNC_ANY_ENTRY_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DWIDTH-1:0] din;
  logic              wen;
  logic              ren;
  logic              full, almost_full, empty, almost_empty;
  logic [DWIDTH-1:0] dout;
  logic [CW-1:0]     count;
  logic              overflow, underflow;

  always #5 clk = ~clk;

  fifo_sync_any_entry #(
    .DEPTH     (DEPTH),
    .DWIDTH    (DWIDTH),
    .AF_THRESH (4),
    .AE_THRESH (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .wen          (wen),
    .full         (full),
    .almost_full  (almost_full),
    .dout         (dout),
    .ren          (ren),
    .empty        (empty),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // fl = {full, almost_full, empty, almost_empty}
  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    int         cnt;
    logic [3:0] fl;
    bit         chk_dout;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[26];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  bit   exp_ovf = 1'b0;
  bit   exp_unf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    wen = w;
    ren = r;
    din = d;
    if (ERR_EN && w && exp_cnt == DEPTH) exp_ovf = 1'b1;
    if (ERR_EN && r && exp_cnt == 0)     exp_unf = 1'b1;
    @(posedge clk);
    #1;
    wen = 1'b0;
    ren = 1'b0;
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic [7:0] d, input int cnt,
                              input logic [3:0] fl, input bit cd, input logic [7:0] dv);
    vec_t v;
    v.w = w; v.r = r; v.d = d; v.cnt = cnt; v.fl = fl; v.chk_dout = cd; v.dout = dv;
    return v;
  endfunction

  initial begin
    logic [7:0] prev;
    logic [7:0] d;

    vecs[0]  = mk(1, 0, 8'h11, 1, 4'b0001, 1, 8'h11);
    vecs[1]  = mk(1, 0, 8'h12, 2, 4'b0001, 1, 8'h11);
    vecs[2]  = mk(1, 0, 8'h13, 3, 4'b0000, 1, 8'h11);
    vecs[3]  = mk(1, 0, 8'h14, 4, 4'b0100, 1, 8'h11);
    vecs[4]  = mk(1, 0, 8'h15, 5, 4'b0100, 1, 8'h11);
    vecs[5]  = mk(1, 0, 8'h16, 6, 4'b1100, 1, 8'h11);
    vecs[6]  = mk(1, 0, 8'h77, 6, 4'b1100, 1, 8'h11);
    vecs[7]  = mk(0, 1, 8'h00, 5, 4'b0100, 1, 8'h12);
    vecs[8]  = mk(0, 1, 8'h00, 4, 4'b0100, 1, 8'h13);
    vecs[9]  = mk(0, 1, 8'h00, 3, 4'b0000, 1, 8'h14);
    vecs[10] = mk(0, 1, 8'h00, 2, 4'b0001, 1, 8'h15);
    vecs[11] = mk(0, 1, 8'h00, 1, 4'b0001, 1, 8'h16);
    vecs[12] = mk(0, 1, 8'h00, 0, 4'b0011, 0, 8'h00);
    vecs[13] = mk(0, 1, 8'h00, 0, 4'b0011, 0, 8'h00);
    vecs[14] = mk(1, 1, 8'hA5, 1, 4'b0001, 1, 8'hA5);
    vecs[15] = mk(1, 0, 8'hB1, 2, 4'b0001, 1, 8'hA5);
    vecs[16] = mk(1, 0, 8'hB2, 3, 4'b0000, 1, 8'hA5);
    vecs[17] = mk(1, 0, 8'hB3, 4, 4'b0100, 1, 8'hA5);
    vecs[18] = mk(1, 0, 8'hB4, 5, 4'b0100, 1, 8'hA5);
    vecs[19] = mk(1, 0, 8'hB5, 6, 4'b1100, 1, 8'hA5);
    vecs[20] = mk(1, 1, 8'hEE, 5, 4'b0100, 1, 8'hB1);
    vecs[21] = mk(0, 1, 8'h00, 4, 4'b0100, 1, 8'hB2);
    vecs[22] = mk(0, 1, 8'h00, 3, 4'b0000, 1, 8'hB3);
    vecs[23] = mk(0, 1, 8'h00, 2, 4'b0001, 1, 8'hB4);
    vecs[24] = mk(0, 1, 8'h00, 1, 4'b0001, 1, 8'hB5);
    vecs[25] = mk(0, 1, 8'h00, 0, 4'b0011, 0, 8'h00);

    rst_n = 1'b0;
    wen   = 1'b0;
    ren   = 1'b0;
    din   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_count", 32'(count), 0);
    chk("reset_flags", {full, almost_full, empty, almost_empty}, 4'b0011);
    chk("reset_ovf", overflow, 0);
    chk("reset_unf", underflow, 0);

    for (int i = 0; i < 26; i++) begin
      step(vecs[i].w, vecs[i].r, vecs[i].d);
      exp_cnt = vecs[i].cnt;
      chk($sformatf("vec%0d_count", i), 32'(count), vecs[i].cnt);
      chk($sformatf("vec%0d_flags", i), {full, almost_full, empty, almost_empty}, vecs[i].fl);
      if (vecs[i].chk_dout) chk($sformatf("vec%0d_dout", i), dout, vecs[i].dout);
      if (i == 6)  chk("overflow_after_full_write", overflow, exp_ovf);
      if (i == 13) chk("underflow_after_empty_read", underflow, exp_unf);
    end
    chk("overflow_sticky", overflow, exp_ovf);
    chk("underflow_sticky", underflow, exp_unf);

    // Interleaved write/read pairs at occupancy 1 wrap both pointers several times.
    step(1, 0, 8'h40);
    exp_cnt = 1;
    prev = 8'h40;
    chk("wrap_seed_dout", dout, prev);
    for (int i = 0; i < 20; i++) begin
      d = 8'h50 + 8'(i);
      step(1, 1, d);
      chk($sformatf("wrap%0d_count", i), 32'(count), 1);
      chk($sformatf("wrap%0d_dout", i), dout, d);
      chk($sformatf("wrap%0d_empty", i), empty, 0);
      prev = d;
    end

    // Bring count to 3, then reset together with a write.
    step(1, 0, 8'h61);
    step(1, 0, 8'h62);
    exp_cnt = 3;
    chk("prerst_count", 32'(count), 3);
    chk("prerst_dout", dout, prev);
    @(negedge clk);
    rst_n = 1'b0;
    wen   = 1'b1;
    din   = 8'h99;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wen   = 1'b0;
    exp_cnt = 0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_flags", {full, almost_full, empty, almost_empty}, 4'b0011);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_unf", underflow, 0);

    step(1, 0, 8'h3C);
    exp_cnt = 1;
    chk("postrst_count", 32'(count), 1);
    chk("postrst_dout", dout, 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
